shift_seq_32: RTL

SHIFT_SEQ_32 -- requirements
Module: shift_seq_32

---
 rtl/shift_seq_32.sv | 113 +++++++++++
 1 files changed

// File: rtl/shift_seq_32.sv
// Iterative 32-bit shifter: shifts one bit position per cycle, left or right (logical/arithmetic),
// with valid/ready handshakes on both request and result sides.
module shift_seq_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] D,
  input  logic [4:0]  amt,
  input  logic        select,
  input  logic        ar_select,
  input  logic        shift_in_right,
  input  logic        shift_in_left,
  output logic [31:0] S,
  output logic        bb_right,
  output logic        bb_left,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_data;
  logic [4:0]  r_count;
  logic        r_sel;
  logic        r_ar;
  logic        r_sir;
  logic        r_sil;
  logic        r_bb_right;
  logic        r_bb_left;
  logic        w_fill;
  logic        w_accept;

  assign w_accept = (r_state == IDLE) && in_valid;
  // Arithmetic fill re-reads the current MSB, which never changes during a right shift.
  assign w_fill   = r_ar ? r_data[31] : r_sil;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = (amt == 5'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (r_count == 5'd1) begin
          w_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data     <= '0;
      r_count    <= '0;
      r_sel      <= 1'b0;
      r_ar       <= 1'b0;
      r_sir      <= 1'b0;
      r_sil      <= 1'b0;
      r_bb_right <= 1'b0;
      r_bb_left  <= 1'b0;
    end else if (w_accept) begin
      r_data     <= D;
      r_count    <= amt;
      r_sel      <= select;
      r_ar       <= ar_select;
      r_sir      <= shift_in_right;
      r_sil      <= shift_in_left;
      r_bb_right <= 1'b0;
      r_bb_left  <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_count <= r_count - 5'd1;
      if (r_sel) begin
        r_data     <= {w_fill, r_data[31:1]};
        r_bb_right <= r_data[0];
      end else begin
        r_data    <= {r_data[30:0], r_sir};
        r_bb_left <= r_data[31];
      end
    end
  end

  assign S        = r_data;
  assign bb_right = r_bb_right;
  assign bb_left  = r_bb_left;

endmodule
